// File: rtl/vx_barrier_ctl_pkg.sv
// rtl/vx_barrier_ctl_pkg.sv - shared sizes and types for the warp-barrier controller
package vx_barrier_ctl_pkg;

  localparam int NUM_WARPS    = 4;
  localparam int NUM_BARRIERS = 4;

  // Index widths never collapse to zero, even for a single warp or barrier.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int NW_BITS = clog2_min1(NUM_WARPS);
  localparam int NB_BITS = clog2_min1(NUM_BARRIERS);

  localparam int BARRIER_CTL_LATENCY = 1;

  typedef struct packed {
    logic               valid;
    logic [NB_BITS-1:0] id;
    logic [NW_BITS-1:0] size_m1;
  } gpu_barrier_t;

  typedef struct packed {
    logic [NUM_WARPS-1:0] mask;
    logic [NW_BITS-1:0]   count;
  } barrier_entry_t;

endpackage

// File: rtl/vx_barrier_entry.sv
// rtl/vx_barrier_entry.sv - one hardware barrier: arrived-warp mask and arrival count
module vx_barrier_entry
  import vx_barrier_ctl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arrive,
  input  logic [NW_BITS-1:0]   wid,
  input  logic [NW_BITS-1:0]   size_m1,
  output logic                 fire,
  output logic [NUM_WARPS-1:0] mask
);

  barrier_entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    // size_m1 is compared per arrival, so whichever arrival matches closes the epoch.
    fire    = arrive && (entry_q.count == size_m1);
    if (arrive) begin
      if (fire) begin
        entry_d = '0;
      end else begin
        entry_d.mask[wid] = 1'b1;
        entry_d.count     = entry_q.count + NW_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign mask = entry_q.mask;

endmodule

// File: rtl/vx_barrier_ctl.sv
// rtl/vx_barrier_ctl.sv - warp-barrier controller: stalls arriving warps, releases them together
module vx_barrier_ctl
  import vx_barrier_ctl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bar_valid,
  input  logic [NW_BITS-1:0]   bar_wid,
  input  logic [NB_BITS-1:0]   bar_id,
  input  logic [NW_BITS-1:0]   bar_size_m1,
  output logic [NUM_WARPS-1:0] stalled_mask,
  output logic                 release_valid,
  output logic [NUM_WARPS-1:0] release_mask,
  output logic                 bar_error
);

  gpu_barrier_t         cmd;
  logic                 illegal;
  logic                 legal;
  logic [NUM_WARPS-1:0] wid_onehot;

  logic [NUM_BARRIERS-1:0] arrive_vec;
  logic [NUM_BARRIERS-1:0] fire_vec;
  logic [NUM_WARPS-1:0]    entry_mask [NUM_BARRIERS];

  logic [NUM_WARPS-1:0] stalled_q, stalled_d;
  logic                 release_valid_q, release_valid_d;
  logic [NUM_WARPS-1:0] release_mask_q, release_mask_d;
  logic                 bar_error_q, bar_error_d;

  always_comb begin
    cmd.valid   = bar_valid;
    cmd.id      = bar_id;
    cmd.size_m1 = bar_size_m1;
  end

  always_comb begin
    wid_onehot          = '0;
    wid_onehot[bar_wid] = 1'b1;
    // A warp already held somewhere cannot arrive again; drop the command untouched.
    illegal = cmd.valid && stalled_q[bar_wid];
    legal   = cmd.valid && !stalled_q[bar_wid];
  end

  for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_entry
    assign arrive_vec[b] = legal && (cmd.id == NB_BITS'(b));

    vx_barrier_entry u_entry (
      .clk     (clk),
      .reset   (reset),
      .arrive  (arrive_vec[b]),
      .wid     (bar_wid),
      .size_m1 (cmd.size_m1),
      .fire    (fire_vec[b]),
      .mask    (entry_mask[b])
    );
  end

  always_comb begin
    stalled_d       = stalled_q;
    release_valid_d = 1'b0;
    release_mask_d  = '0;
    bar_error_d     = illegal;
    if (legal) begin
      if (fire_vec[cmd.id]) begin
        // The issuing warp was never marked stalled, so only the held warps clear.
        release_valid_d = 1'b1;
        release_mask_d  = entry_mask[cmd.id] | wid_onehot;
        stalled_d       = stalled_q & ~entry_mask[cmd.id];
      end else begin
        stalled_d = stalled_q | wid_onehot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stalled_q       <= '0;
      release_valid_q <= 1'b0;
      release_mask_q  <= '0;
      bar_error_q     <= 1'b0;
    end else begin
      stalled_q       <= stalled_d;
      release_valid_q <= release_valid_d;
      release_mask_q  <= release_mask_d;
      bar_error_q     <= bar_error_d;
    end
  end

  assign stalled_mask  = stalled_q;
  assign release_valid = release_valid_q;
  assign release_mask  = release_mask_q;
  assign bar_error     = bar_error_q;

endmodule

// File: tb/tb_vx_barrier_ctl.sv
// tb/tb_vx_barrier_ctl.sv - scoreboard bench for vx_barrier_ctl against a queue-based barrier model
module tb_vx_barrier_ctl;

  logic       clk = 1'b0;
  logic       reset;
  logic       bar_valid;
  logic [1:0] bar_wid;
  logic [1:0] bar_id;
  logic [1:0] bar_size_m1;
  logic [3:0] stalled_mask;
  logic       release_valid;
  logic [3:0] release_mask;
  logic       bar_error;

  vx_barrier_ctl dut (
    .clk           (clk),
    .reset         (reset),
    .bar_valid     (bar_valid),
    .bar_wid       (bar_wid),
    .bar_id        (bar_id),
    .bar_size_m1   (bar_size_m1),
    .stalled_mask  (stalled_mask),
    .release_valid (release_valid),
    .release_mask  (release_mask),
    .bar_error     (bar_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [3:0] st;
    logic       rv;
    logic [3:0] rm;
    logic       er;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Model: each barrier is the ordered list of warps waiting on it.
  int arr[4][$];

  function automatic logic [3:0] model_stalled();
    logic [3:0] m;
    m = '0;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < arr[b].size(); i++)
        m[arr[b][i]] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("stalled_mask", stalled_mask, e.st);
      chk("release_valid", {3'b0, release_valid}, {3'b0, e.rv});
      chk("release_mask", release_mask, e.rm);
      chk("bar_error", {3'b0, bar_error}, {3'b0, e.er});
    end
  end

  task automatic step(input logic v, input int w, input int b, input int s, input logic r);
    exp_t       e;
    logic [3:0] st;
    @(posedge clk);
    #1;
    reset       = r;
    bar_valid   = v;
    bar_wid     = w[1:0];
    bar_id      = b[1:0];
    bar_size_m1 = s[1:0];
    e.due = cyc + 1;
    e.rv  = 1'b0;
    e.rm  = '0;
    e.er  = 1'b0;
    if (r) begin
      for (int k = 0; k < 4; k++) arr[k].delete();
    end else if (v) begin
      st = model_stalled();
      if (st[w]) begin
        e.er = 1'b1;
      end else if (arr[b].size() == s) begin
        e.rv = 1'b1;
        e.rm = model_stalled() & 4'h0;
        for (int i = 0; i < arr[b].size(); i++) e.rm[arr[b][i]] = 1'b1;
        e.rm[w] = 1'b1;
        arr[b].delete();
      end else begin
        arr[b].push_back(w);
      end
    end
    e.st = model_stalled();
    sbq.push_back(e);
  endtask

  task automatic cmd(input int w, input int b, input int s);
    step(1'b1, w, b, s, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    int         r, w, b, s;
    logic [3:0] st;
    reset       = 1'b1;
    bar_valid   = 1'b0;
    bar_wid     = '0;
    bar_id      = '0;
    bar_size_m1 = '0;

    // Commands under reset must be ignored.
    step(1'b1, 0, 0, 0, 1'b1);
    step(1'b1, 1, 2, 1, 1'b1);
    step(1'b0, 0, 0, 0, 1'b1);
    idle(10);

    // Four warps on barrier 1.
    cmd(0, 1, 3); cmd(2, 1, 3); cmd(1, 1, 3); cmd(3, 1, 3);
    idle(2);
    // Single-warp barrier.
    cmd(2, 0, 0);
    idle(1);
    // Interleaved barriers.
    cmd(0, 0, 1); cmd(1, 3, 1); cmd(2, 3, 1); cmd(3, 0, 1);
    idle(1);
    // Illegal re-issue from a stalled warp, then prove barrier 0 is untouched.
    cmd(1, 2, 1); cmd(1, 0, 0); cmd(2, 0, 0); cmd(3, 2, 1);
    idle(1);
    // Reset mid-barrier, then a fresh pair.
    cmd(0, 1, 3); cmd(1, 1, 3); cmd(2, 1, 3);
    step(1'b0, 0, 0, 0, 1'b1);
    idle(1);
    cmd(0, 1, 1); cmd(1, 1, 1);
    idle(2);

    for (int k = 0; k < 800; k++) begin
      r  = $urandom_range(0, 99);
      st = model_stalled();
      if (r < 3 || (st == 4'hF && r < 40)) begin
        step(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      end else if (r < 15) begin
        idle(1);
      end else begin
        b = $urandom_range(0, 3);
        if ((r < 25 && st != 4'h0) || st == 4'hF) begin
          do w = $urandom_range(0, 3); while (!st[w]);
          s = $urandom_range(0, 3);
        end else begin
          do w = $urandom_range(0, 3); while (st[w]);
          s = $urandom_range(3, arr[b].size());
        end
        cmd(w, b, s);
      end
    end
    idle(2);

    repeat (3) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d want=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
